cpu_run_ctrl: RTL and testbench

- Synthesizable run controller for CPU bring-up. It replaces the fixed "hold reset, run N cycles, stop" sequence with a parametrised, reusable block.
- Sequences a core-side reset, counts run cycles, tracks per-channel retire counts and halt flags, and ends each run in PASS or TIMEOUT.
- Sits between board/bench clock-reset and one or more My_CPU instances (NUM_CH channels).

---
 rtl/cpu_run_pkg.sv | 25 ++
 rtl/run_sat_cnt.sv | 26 ++
 rtl/cpu_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the CPU run controller.
// Optional stall detection is built only when RUN_CTRL_STALL_DET_EN is defined;
// the STALL state is always present in the enum so debug decoding is stable.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        RUN     = 3'd2,
        PASS    = 3'd3,
        TIMEOUT = 3'd4,
        STALL   = 3'd5
    } run_state_e;

    localparam int DEF_RST_CYCLES   = 5;
    localparam int DEF_MAX_CYCLES   = 100;
    localparam int DEF_STALL_CYCLES = 16;

    // Saturating-increment gate: a counter may step only when enabled and not
    // already at all-ones, so counters stick at their maximum instead of wrapping.
    function automatic logic sat_can_inc(input logic en, input logic at_max);
        return en && !at_max;
    endfunction

endpackage

// File: rtl/run_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable.
// Clear has priority over enable; the count holds at all-ones.
module run_sat_cnt
    import cpu_run_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    // Count register: async clear on reset, sync clear on launch, saturate at max.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (sat_can_inc(en, &q)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU bring-up: holds the cores in reset after a launch,
// counts run cycles and per-channel retirements, and ends each run in PASS
// (all channels halted) or TIMEOUT (cycle budget used up).
// Optional macro RUN_CTRL_STALL_DET_EN adds a STALL exit when no channel has
// retired anything for STALL_CYCLES consecutive run cycles.
// MAX_CYCLES must fit in CNT_W bits so the budget compare can be reached.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int NUM_CH     = 1,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = 32
`ifdef RUN_CTRL_STALL_DET_EN
    ,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       halt,
    input  logic [NUM_CH-1:0]       commit_valid,
    output logic                    core_rst,
    output logic                    running,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [NUM_CH*CNT_W-1:0] retire_cnt,
`ifdef RUN_CTRL_STALL_DET_EN
    output logic                    stall,
`endif
    output logic [2:0]              state_dbg
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    run_state_e          state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_CH-1:0]   halt_cap;
    logic [NUM_CH-1:0]   halt_view;
    logic                all_halt;
    logic                last_cycle;
    logic                in_run;
    logic                launch;
    logic                stall_hit;
    logic                cyc_en;

`ifdef RUN_CTRL_STALL_DET_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0]  stall_cnt;
    logic                no_commit;
`endif

    assign state_dbg = state;

    // Exit conditions use the current-cycle halt view so a halt seen in the
    // final budget cycle still counts as PASS.
    always_comb begin
        halt_view  = halt_cap | halt;
        all_halt   = &halt_view;
        last_cycle = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
        in_run     = (state == RUN);
        launch     = start && ((state == IDLE) || (state == PASS) ||
                               (state == TIMEOUT) || (state == STALL));
        stall_hit  = 1'b0;
`ifdef RUN_CTRL_STALL_DET_EN
        no_commit  = ~|commit_valid;
        stall_hit  = no_commit && (stall_cnt == STALL_W'(STALL_CYCLES - 1));
`endif
        // The cycle count freezes on the exit cycle, so a full-budget run
        // reports MAX_CYCLES-1 (the index of its last run cycle).
        cyc_en     = in_run && !(all_halt || stall_hit || last_cycle);
    end

    // Main sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            halt_cap <= '0;
            core_rst <= 1'b1;
            running  <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
`ifdef RUN_CTRL_STALL_DET_EN
            stall     <= 1'b0;
            stall_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE, PASS, TIMEOUT, STALL: begin
                    if (start) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        halt_cap <= '0;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        timeout  <= 1'b0;
`ifdef RUN_CTRL_STALL_DET_EN
                        stall     <= 1'b0;
                        stall_cnt <= '0;
`endif
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    halt_cap <= halt_view;
`ifdef RUN_CTRL_STALL_DET_EN
                    stall_cnt <= no_commit ? (stall_cnt + STALL_W'(1)) : '0;
`endif
                    if (all_halt) begin
                        state    <= PASS;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b1;
`ifdef RUN_CTRL_STALL_DET_EN
                    end else if (stall_hit) begin
                        state    <= STALL;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        stall    <= 1'b1;
`endif
                    end else if (last_cycle) begin
                        state    <= TIMEOUT;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    core_rst <= 1'b1;
                    running  <= 1'b0;
                end
            endcase
        end
    end

    run_sat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (cyc_en),
        .q   (cycle_cnt)
    );

    // Retire counters count every run cycle, including the exit cycle.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_retire
        run_sat_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
            .clk (clk),
            .rst (rst),
            .clr (launch),
            .en  (in_run && commit_valid[i]),
            .q   (retire_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (default build, stall detection disabled).
// Main instance: NUM_CH=2, RST_CYCLES=5, MAX_CYCLES=100, CNT_W=32.
// Small instance: NUM_CH=1, RST_CYCLES=1, MAX_CYCLES=16, CNT_W=4 for saturation.
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        start;
    logic [1:0]  halt;
    logic [1:0]  commit_valid;
    logic        core_rst, running, done, pass, timeout;
    logic [31:0] cycle_cnt;
    logic [63:0] retire_cnt;
    logic [2:0]  state_dbg;

    logic        s_start;
    logic [0:0]  s_halt;
    logic [0:0]  s_commit;
    logic        s_core_rst, s_running, s_done, s_pass, s_timeout;
    logic [3:0]  s_cycle_cnt;
    logic [3:0]  s_retire_cnt;
    logic [2:0]  s_state_dbg;

    cpu_run_ctrl #(.NUM_CH(2), .RST_CYCLES(5), .MAX_CYCLES(100), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt         (halt),
        .commit_valid (commit_valid),
        .core_rst     (core_rst),
        .running      (running),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt),
        .state_dbg    (state_dbg)
    );

    cpu_run_ctrl #(.NUM_CH(1), .RST_CYCLES(1), .MAX_CYCLES(16), .CNT_W(4)) dut_s (
        .clk          (clk),
        .rst          (rst),
        .start        (s_start),
        .halt         (s_halt),
        .commit_valid (s_commit),
        .core_rst     (s_core_rst),
        .running      (s_running),
        .done         (s_done),
        .pass         (s_pass),
        .timeout      (s_timeout),
        .cycle_cnt    (s_cycle_cnt),
        .retire_cnt   (s_retire_cnt),
        .state_dbg    (s_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input logic [2:0] act, input run_state_e exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got state %0d, expected state %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at posedge+1; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the five HOLD cycles following a launch edge and the RUN entry.
    task automatic hold_check();
        for (int i = 0; i < 5; i++) begin
            chk1($sformatf("hold%0d.core_rst", i), core_rst, 1'b1);
            chk1($sformatf("hold%0d.running", i), running, 1'b0);
            step();
        end
        chk_st("run_entry.state", state_dbg, RUN);
        chk1("run_entry.core_rst", core_rst, 1'b0);
        chk1("run_entry.running", running, 1'b1);
        chk("run_entry.cycle_cnt", cycle_cnt, 32'd0);
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        chk_st("launch.state", state_dbg, HOLD);
        chk("launch.cycle_clr", cycle_cnt, 32'd0);
        chk("launch.ret0_clr", retire_cnt[31:0], 32'd0);
        chk("launch.ret1_clr", retire_cnt[63:32], 32'd0);
        chk1("launch.done_clr", done, 1'b0);
        hold_check();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       s;
        logic [1:0] h;
        logic [1:0] c;
        run_state_e st;
        logic       cr, ru, dn, ps, to;
        int         cy, r0, r1;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [1:0] h, input logic [1:0] c,
                                input run_state_e st, input logic cr, input logic ru,
                                input logic dn, input logic ps, input logic to,
                                input int cy, input int r0, input int r1);
        vec_t v;
        v.s = s; v.h = h; v.c = c; v.st = st;
        v.cr = cr; v.ru = ru; v.dn = dn; v.ps = ps; v.to = to;
        v.cy = cy; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    vec_t vecs[14];

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        //           s     h      c      state    cr ru dn ps to  cyc r0 r1
        vecs[0]  = mk(1'b0, 2'b00, 2'b00, IDLE,    1, 0, 0, 0, 0,  0, 0, 0);
        vecs[1]  = mk(1'b1, 2'b00, 2'b00, HOLD,    1, 0, 0, 0, 0,  0, 0, 0);
        vecs[2]  = mk(1'b0, 2'b00, 2'b00, HOLD,    1, 0, 0, 0, 0,  0, 0, 0);
        vecs[3]  = mk(1'b0, 2'b00, 2'b00, HOLD,    1, 0, 0, 0, 0,  0, 0, 0);
        vecs[4]  = mk(1'b0, 2'b00, 2'b00, HOLD,    1, 0, 0, 0, 0,  0, 0, 0);
        vecs[5]  = mk(1'b0, 2'b00, 2'b00, HOLD,    1, 0, 0, 0, 0,  0, 0, 0);
        vecs[6]  = mk(1'b0, 2'b00, 2'b00, RUN,     0, 1, 0, 0, 0,  0, 0, 0);
        vecs[7]  = mk(1'b1, 2'b00, 2'b11, RUN,     0, 1, 0, 0, 0,  1, 1, 1);
        vecs[8]  = mk(1'b0, 2'b00, 2'b01, RUN,     0, 1, 0, 0, 0,  2, 2, 1);
        vecs[9]  = mk(1'b0, 2'b01, 2'b10, RUN,     0, 1, 0, 0, 0,  3, 2, 2);
        vecs[10] = mk(1'b0, 2'b00, 2'b00, RUN,     0, 1, 0, 0, 0,  4, 2, 2);
        vecs[11] = mk(1'b0, 2'b10, 2'b11, PASS,    1, 0, 1, 1, 0,  4, 3, 3);
        vecs[12] = mk(1'b0, 2'b00, 2'b11, PASS,    1, 0, 1, 1, 0,  4, 3, 3);
        vecs[13] = mk(1'b1, 2'b00, 2'b00, HOLD,    1, 0, 0, 0, 0,  0, 0, 0);

        rst          = 1'b0;
        start        = 1'b0;
        halt         = 2'b00;
        commit_valid = 2'b00;
        s_start      = 1'b0;
        s_halt       = 1'b0;
        s_commit     = 1'b0;

        // Reset values
        #12;
        chk_st("reset.state", state_dbg, IDLE);
        chk1("reset.core_rst", core_rst, 1'b1);
        chk1("reset.running", running, 1'b0);
        chk1("reset.done", done, 1'b0);
        chk1("reset.pass", pass, 1'b0);
        chk1("reset.timeout", timeout, 1'b0);
        chk("reset.cycle_cnt", cycle_cnt, 32'd0);
        chk("reset.retire0", retire_cnt[31:0], 32'd0);
        chk("reset.retire1", retire_cnt[63:32], 32'd0);
        rst = 1'b1;
        step();

        // Table: launch, hold, run with sticky halts, PASS, restart from PASS.
        // Row 7 also pulses start during RUN, which must be ignored.
        for (int i = 0; i < 14; i++) begin
            start        = vecs[i].s;
            halt         = vecs[i].h;
            commit_valid = vecs[i].c;
            step();
            chk_st($sformatf("row%0d.state", i), state_dbg, vecs[i].st);
            chk1($sformatf("row%0d.core_rst", i), core_rst, vecs[i].cr);
            chk1($sformatf("row%0d.running", i), running, vecs[i].ru);
            chk1($sformatf("row%0d.done", i), done, vecs[i].dn);
            chk1($sformatf("row%0d.pass", i), pass, vecs[i].ps);
            chk1($sformatf("row%0d.timeout", i), timeout, vecs[i].to);
            chk($sformatf("row%0d.cycle_cnt", i), cycle_cnt, 32'(vecs[i].cy));
            chk($sformatf("row%0d.retire0", i), retire_cnt[31:0], 32'(vecs[i].r0));
            chk($sformatf("row%0d.retire1", i), retire_cnt[63:32], 32'(vecs[i].r1));
        end
        start        = 1'b0;
        halt         = 2'b00;
        commit_valid = 2'b00;

        // Two-channel PASS: commits on cycles 0..9, halt[0] pulse at 12, halt[1] at 20.
        hold_check();
        for (int k = 0; k <= 20; k++) begin
            commit_valid = (k < 10) ? 2'b11 : 2'b00;
            halt         = (k == 12) ? 2'b01 : ((k == 20) ? 2'b10 : 2'b00);
            exp_q.push_back((k < 20) ? 32'(k + 1) : 32'd20);
            step();
            chk($sformatf("pass_run.cycle%0d", k), cycle_cnt, exp_q.pop_front());
            if (k == 19) chk1("pass_run.not_yet", pass, 1'b0);
        end
        halt         = 2'b00;
        commit_valid = 2'b00;
        chk_st("pass_run.state", state_dbg, PASS);
        chk1("pass_run.pass", pass, 1'b1);
        chk1("pass_run.done", done, 1'b1);
        chk1("pass_run.timeout", timeout, 1'b0);
        chk1("pass_run.core_rst", core_rst, 1'b1);
        chk("pass_run.retire0", retire_cnt[31:0], 32'd10);
        chk("pass_run.retire1", retire_cnt[63:32], 32'd10);

        // TIMEOUT after exactly 100 run cycles with no halts.
        launch();
        idle_steps(99);
        chk_st("to.last_cycle_state", state_dbg, RUN);
        chk("to.last_cycle_cnt", cycle_cnt, 32'd99);
        chk1("to.last_cycle_timeout", timeout, 1'b0);
        step();
        chk_st("to.state", state_dbg, TIMEOUT);
        chk1("to.timeout", timeout, 1'b1);
        chk1("to.done", done, 1'b1);
        chk1("to.pass", pass, 1'b0);
        chk1("to.core_rst", core_rst, 1'b1);
        chk1("to.running", running, 1'b0);
        chk("to.cycle_cnt", cycle_cnt, 32'd99);
        chk("to.retire0", retire_cnt[31:0], 32'd0);
        chk("to.retire1", retire_cnt[63:32], 32'd0);
        idle_steps(3);
        chk1("to.sticky", timeout, 1'b1);
        chk("to.cnt_hold", cycle_cnt, 32'd99);

        // All-halt on the last budget cycle: PASS wins over TIMEOUT.
        launch();
        idle_steps(99);
        halt = 2'b11;
        step();
        halt = 2'b00;
        chk_st("edge.state", state_dbg, PASS);
        chk1("edge.pass", pass, 1'b1);
        chk1("edge.timeout", timeout, 1'b0);
        chk("edge.cycle_cnt", cycle_cnt, 32'd99);

        // Async reset in the middle of a run.
        launch();
        commit_valid = 2'b11;
        idle_steps(30);
        commit_valid = 2'b00;
        chk("arst.pre_cycle", cycle_cnt, 32'd30);
        chk("arst.pre_ret0", retire_cnt[31:0], 32'd30);
        #2;
        rst = 1'b0;
        #1;
        chk_st("arst.state", state_dbg, IDLE);
        chk1("arst.core_rst", core_rst, 1'b1);
        chk1("arst.running", running, 1'b0);
        chk("arst.cycle_cnt", cycle_cnt, 32'd0);
        chk("arst.retire0", retire_cnt[31:0], 32'd0);
        chk("arst.retire1", retire_cnt[63:32], 32'd0);
        #2;
        rst = 1'b1;
        step();
        chk_st("arst.idle_after", state_dbg, IDLE);
        launch();
        commit_valid = 2'b01;
        start        = 1'b1;
        idle_steps(3);
        start        = 1'b0;
        commit_valid = 2'b00;
        chk_st("relaunch.state", state_dbg, RUN);
        chk("relaunch.cycle_cnt", cycle_cnt, 32'd3);
        chk("relaunch.retire0", retire_cnt[31:0], 32'd3);
        chk("relaunch.retire1", retire_cnt[63:32], 32'd0);

        // Saturation on the 4-bit instance: 16 commits saturate retire at 15.
        s_commit = 1'b1;
        s_start  = 1'b1;
        step();
        s_start = 1'b0;
        chk_st("sat.hold", s_state_dbg, HOLD);
        step();
        chk_st("sat.run", s_state_dbg, RUN);
        chk1("sat.core_rst", s_core_rst, 1'b0);
        idle_steps(15);
        chk("sat.cycle15", 32'(s_cycle_cnt), 32'd15);
        chk("sat.retire15", 32'(s_retire_cnt), 32'd15);
        chk1("sat.not_timeout", s_timeout, 1'b0);
        step();
        s_commit = 1'b0;
        chk_st("sat.state", s_state_dbg, TIMEOUT);
        chk1("sat.timeout", s_timeout, 1'b1);
        chk("sat.retire_sat", 32'(s_retire_cnt), 32'd15);
        chk("sat.cycle_final", 32'(s_cycle_cnt), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
